// File: rtl/ikaopll_pg_multislot_if.sv
// Slot bus between the operator sequencer and the multislot phase generator.
// master: drives per-slot operator parameters and the debug read address.
// slave : returns operator phase/slot/valid and debug phase readback.
interface ikaopll_pg_multislot_if #(
  parameter int unsigned NUM_SLOTS = 18,
  parameter int unsigned FNUM_W    = 9,
  parameter int unsigned BLOCK_W   = 3,
  parameter int unsigned PHASE_W   = 19,
  parameter int unsigned OUT_W     = 10
);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

  logic               i_SYNC;
  logic [FNUM_W-1:0]  i_FNUM;
  logic [BLOCK_W-1:0] i_BLOCK;
  logic [3:0]         i_MUL;
  logic               i_PM;
  logic [2:0]         i_PMVAL;
  logic               i_PHASE_RST;
  logic               i_HOLD;
  logic [SLOT_W-1:0]  i_RD_SLOT;
  logic [PHASE_W-1:0] o_RD_PHASE;
  logic [OUT_W-1:0]   o_OP_PHASE;
  logic [SLOT_W-1:0]  o_OP_SLOT;
  logic               o_OP_VALID;

  modport master (
    output i_SYNC, i_FNUM, i_BLOCK, i_MUL, i_PM, i_PMVAL, i_PHASE_RST, i_HOLD, i_RD_SLOT,
    input  o_RD_PHASE, o_OP_PHASE, o_OP_SLOT, o_OP_VALID
  );

  modport slave (
    input  i_SYNC, i_FNUM, i_BLOCK, i_MUL, i_PM, i_PMVAL, i_PHASE_RST, i_HOLD, i_RD_SLOT,
    output o_RD_PHASE, o_OP_PHASE, o_OP_SLOT, o_OP_VALID
  );
endinterface

// File: rtl/ikaopll_pg_multislot.sv
// Time-multiplexed FM phase generator: one accumulator per slot held in an
// indexed phase memory, with vibrato, block shift, MUL scaling, per-slot
// phase reset / hold and a combinational debug readback.
// Ports:
//   i_EMUCLK  master clock
//   i_RST     synchronous active-high reset (ignores i_CEN_n)
//   i_CEN_n   active-low clock enable, one slot per enabled cycle
//   bus       slot parameters in, operator phase/slot/valid and debug read out
module ikaopll_pg_multislot #(
  parameter int unsigned NUM_SLOTS = 18,
  parameter int unsigned FNUM_W    = 9,
  parameter int unsigned BLOCK_W   = 3,
  parameter int unsigned PHASE_W   = 19,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned MUL_MODE  = 0
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_CEN_n,
  ikaopll_pg_multislot_if.slave    bus
);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned MOD_W  = FNUM_W + 2;
  localparam int unsigned SH_W   = MOD_W + (1 << BLOCK_W);
  localparam int unsigned PROD_W = PHASE_W + 5;

  logic [PHASE_W-1:0] r_mem [NUM_SLOTS];

  logic [SLOT_W-1:0]  r_slot_cnt;
  logic               r_framed;

  logic               r1_valid, r1_hold, r1_prst;
  logic [SLOT_W-1:0]  r1_slot;
  logic [PHASE_W-1:0] r1_delta, r1_prev;
  logic [4:0]         r1_mul_x2;

  logic               r2_valid, r2_hold, r2_prst;
  logic [SLOT_W-1:0]  r2_slot;
  logic [PHASE_W-1:0] r2_prod, r2_prev;

  logic [SLOT_W-1:0]  w_cur_slot, w_next_cnt;
  logic               w_slot_vld;
  logic [2:0]         w_pm_mag;
  logic               w_pm_sign;
  logic [MOD_W-1:0]   w_base, w_modded;
  logic [SH_W-1:0]    w_shifted;
  logic [PHASE_W-1:0] w_delta, w_new;
  logic [4:0]         w_mul_x2;

  // Slot tagging: SYNC forces slot 0, otherwise the running counter.
  always_comb begin
    w_cur_slot = bus.i_SYNC ? '0 : r_slot_cnt;
    w_next_cnt = (w_cur_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : w_cur_slot + SLOT_W'(1);
    w_slot_vld = bus.i_SYNC | r_framed;
  end

  // Vibrato offset derived from the top F-number bits.
  always_comb begin
    w_pm_mag  = '0;
    w_pm_sign = 1'b0;
    if (bus.i_PM) begin
      w_pm_sign = bus.i_PMVAL[2];
      case (bus.i_PMVAL[1:0])
        2'd0:    w_pm_mag = '0;
        2'd2:    w_pm_mag = bus.i_FNUM[FNUM_W-1 -: 3];
        default: w_pm_mag = {1'b0, bus.i_FNUM[FNUM_W-1 -: 2]};
      endcase
    end
  end

  // Modded F-number: add keeps carry, subtract wraps with MSB cleared.
  always_comb begin
    w_base = {1'b0, bus.i_FNUM, 1'b0};
    if (w_pm_sign)
      w_modded = {1'b0, w_base[MOD_W-2:0] - (MOD_W-1)'(w_pm_mag)};
    else
      w_modded = w_base + MOD_W'(w_pm_mag);
    w_shifted = SH_W'(w_modded) << bus.i_BLOCK;
    w_delta   = PHASE_W'(w_shifted >> 1);
  end

  // MUL code to twice the multiplier so the 0.5 entry stays integral.
  always_comb begin
    w_mul_x2 = {bus.i_MUL, 1'b0};
    if (bus.i_MUL == 4'd0) begin
      w_mul_x2 = 5'd1;
    end else if (MUL_MODE == 0) begin
      case (bus.i_MUL)
        4'd11:       w_mul_x2 = 5'd20;
        4'd13:       w_mul_x2 = 5'd24;
        4'd14, 4'd15: w_mul_x2 = 5'd30;
        default:     w_mul_x2 = {bus.i_MUL, 1'b0};
      endcase
    end
  end

  // Phase-reset takes priority over hold; prev is already zero in that case.
  always_comb begin
    if (r2_prst)
      w_new = r2_prod;
    else if (r2_hold)
      w_new = r2_prev;
    else
      w_new = r2_prev + r2_prod;
  end

  assign bus.o_RD_PHASE = ({1'b0, bus.i_RD_SLOT} < (SLOT_W+1)'(NUM_SLOTS)) ?
                          r_mem[bus.i_RD_SLOT] : '0;

  // Counter, three-stage pipeline, phase memory and output registers.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_slot_cnt     <= '0;
      r_framed       <= 1'b0;
      r1_valid       <= 1'b0;
      r1_hold        <= 1'b0;
      r1_prst        <= 1'b0;
      r1_slot        <= '0;
      r1_delta       <= '0;
      r1_prev        <= '0;
      r1_mul_x2      <= '0;
      r2_valid       <= 1'b0;
      r2_hold        <= 1'b0;
      r2_prst        <= 1'b0;
      r2_slot        <= '0;
      r2_prod        <= '0;
      r2_prev        <= '0;
      bus.o_OP_PHASE <= '0;
      bus.o_OP_SLOT  <= '0;
      bus.o_OP_VALID <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_mem[SLOT_W'(i)] <= '0;
    end else if (!i_CEN_n) begin
      r_slot_cnt <= w_next_cnt;
      r_framed   <= r_framed | bus.i_SYNC;

      r1_valid  <= w_slot_vld;
      r1_slot   <= w_cur_slot;
      r1_delta  <= w_delta;
      r1_mul_x2 <= w_mul_x2;
      r1_prev   <= bus.i_PHASE_RST ? '0 : r_mem[w_cur_slot];
      r1_hold   <= bus.i_HOLD;
      r1_prst   <= bus.i_PHASE_RST;

      r2_valid <= r1_valid;
      r2_slot  <= r1_slot;
      r2_prod  <= PHASE_W'((PROD_W'(r1_delta) * PROD_W'(r1_mul_x2)) >> 1);
      r2_prev  <= r1_prev;
      r2_hold  <= r1_hold;
      r2_prst  <= r1_prst;

      bus.o_OP_VALID <= r2_valid;
      if (r2_valid) begin
        r_mem[r2_slot] <= w_new;
        bus.o_OP_PHASE <= w_new[PHASE_W-1 -: OUT_W];
        bus.o_OP_SLOT  <= r2_slot;
      end
    end
  end
endmodule
